// File: rtl/painter_pkg.sv
// Shared grid geometry, FSM state encoding and small helpers for the
// grid path painter.
package painter_pkg;

  localparam int GRID_W     = 64;
  localparam int GRID_H     = 60;
  localparam int GRID_WORDS = 960;

  typedef enum logic [2:0] {
    IDLE,
    PAINT_WR,
    CLR_RD,
    CLR_WAIT,
    CLR_WR,
    CLR_DONE
  } state_t;

  // One-hot byte enable for a byte lane within a 32-bit word.
  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/painter_fifo.sv
// Cell-command FIFO: stores 12-bit cell indices, exposes occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module painter_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/grid_path_painter.sv
// Grid path painter: paints queued cells into a 64x60 byte-per-cell
// framebuffer over Avalon-MM, and on request sweeps all 960 words replacing
// PATH_COLOR bytes with EMPTY_COLOR.
// Optional feature macro: PAINTER_BOUNDS_CHECK_EN drops pushes with row > 59
// and counts them in err_count (saturating).
module grid_path_painter
  import painter_pkg::*;
#(
  parameter logic [7:0] PATH_COLOR  = 8'd3,
  parameter logic [7:0] EMPTY_COLOR = 8'd0,
  parameter int         FIFO_DEPTH  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [5:0]  push_x,
  input  logic [5:0]  push_y,
  input  logic        clear_start,
  output logic        busy,
  output logic        clear_done,
  output logic [9:0]  AVM_ADDRESS,
  output logic        AVM_READ,
  output logic        AVM_WRITE,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic [31:0] AVM_READDATA,
  input  logic        AVM_READDATAVALID,
  input  logic        AVM_WAIT_REQUEST,
  output logic [7:0]  err_count
);

  localparam logic [5:0] Y_LAST    = 6'(GRID_H - 1);
  localparam logic [9:0] WORD_LAST = 10'(GRID_WORDS - 1);
  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic          pending;
  logic [9:0]    word_ptr;
  logic [11:0]   push_index;
  logic [11:0]   head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          accept;
  logic          enqueue;
  logic          in_clear;
  logic          last_word;
  logic [3:0]    match_mask;

  // Cell index = x + 64*y, which is simply the concatenation.
  assign push_index = {push_y, push_x};
  assign accept     = push_valid && push_ready;
  assign fifo_pop   = (state == PAINT_WR) && !AVM_WAIT_REQUEST;
  assign push_ready = !fifo_full || fifo_pop;
  assign in_clear   = (state == CLR_RD) || (state == CLR_WAIT) ||
                      (state == CLR_WR) || (state == CLR_DONE);
  assign last_word  = (word_ptr == WORD_LAST);
  assign busy       = (fifo_count != '0) || pending || (state != IDLE);

`ifdef PAINTER_BOUNDS_CHECK_EN
  assign enqueue = accept && (push_y <= Y_LAST);

  // Count rejected rows, saturating at 255.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_count <= '0;
    end else if (accept && (push_y > Y_LAST) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign enqueue   = accept;
  assign err_count = '0;
`endif

  painter_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (12)
  ) u_fifo (
    .clk   (Clk),
    .reset (Reset),
    .push  (enqueue),
    .wdata (push_index),
    .pop   (fifo_pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Byte lanes of the returned word that hold the path color.
  always_comb begin
    match_mask = '0;
    for (int i = 0; i < 4; i++) begin
      match_mask[i] = (AVM_READDATA[8*i +: 8] == PATH_COLOR);
    end
  end

  // Sequencer for paint writes and the read-modify-write clear sweep.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      word_ptr      <= '0;
      clear_done    <= 1'b0;
      AVM_ADDRESS   <= '0;
      AVM_READ      <= 1'b0;
      AVM_WRITE     <= 1'b0;
      AVM_BYTE_EN   <= '0;
      AVM_WRITEDATA <= '0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            pending     <= 1'b0;
            word_ptr    <= '0;
            AVM_ADDRESS <= '0;
            AVM_BYTE_EN <= 4'hF;
            AVM_READ    <= 1'b1;
            state       <= CLR_RD;
          end else if (!fifo_empty) begin
            AVM_ADDRESS   <= head[11:2];
            AVM_BYTE_EN   <= lane_onehot(head[1:0]);
            AVM_WRITEDATA <= {4{PATH_COLOR}};
            AVM_WRITE     <= 1'b1;
            state         <= PAINT_WR;
          end
        end
        PAINT_WR: begin
          if (!AVM_WAIT_REQUEST) begin
            AVM_WRITE <= 1'b0;
            state     <= IDLE;
          end
        end
        CLR_RD: begin
          if (!AVM_WAIT_REQUEST) begin
            AVM_READ <= 1'b0;
            state    <= CLR_WAIT;
          end
        end
        CLR_WAIT: begin
          if (AVM_READDATAVALID) begin
            if (match_mask != 4'b0000) begin
              AVM_BYTE_EN   <= match_mask;
              AVM_WRITEDATA <= {4{EMPTY_COLOR}};
              AVM_WRITE     <= 1'b1;
              state         <= CLR_WR;
            end else if (last_word) begin
              clear_done <= 1'b1;
              state      <= CLR_DONE;
            end else begin
              word_ptr    <= word_ptr + 10'd1;
              AVM_ADDRESS <= word_ptr + 10'd1;
              AVM_BYTE_EN <= 4'hF;
              AVM_READ    <= 1'b1;
              state       <= CLR_RD;
            end
          end
        end
        CLR_WR: begin
          if (!AVM_WAIT_REQUEST) begin
            AVM_WRITE <= 1'b0;
            if (last_word) begin
              clear_done <= 1'b1;
              state      <= CLR_DONE;
            end else begin
              word_ptr    <= word_ptr + 10'd1;
              AVM_ADDRESS <= word_ptr + 10'd1;
              AVM_BYTE_EN <= 4'hF;
              AVM_READ    <= 1'b1;
              state       <= CLR_RD;
            end
          end
        end
        CLR_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
      // A request arriving while a sweep is underway (or about to start) is dropped.
      if (clear_start && !in_clear && !(state == IDLE && pending)) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
